// File: rtl/alu_div_sequencer.sv
// 24-bit unsigned restoring divider that sequences an external ALU24bit as its subtractor.
// One quotient bit is produced per ITER cycle; Done pulses for one cycle with the results.
module alu_div_sequencer #(
   parameter int unsigned WIDTH  = 24,
   parameter logic [2:0]  OP_ADD = 3'b010,
   parameter int unsigned CNT_W  = 5
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivByZero,
   output logic [WIDTH-1:0] AluA,
   output logic [WIDTH-1:0] AluB,
   output logic             AluAInvert,
   output logic             AluBNegate,
   output logic [2:0]       AluOp,
   input  logic [WIDTH-1:0] AluResult,
   input  logic             AluCarryOut
);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   r_q, r_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic               dbz_q, dbz_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   alu_a_q, alu_a_d;
   logic [WIDTH-1:0]   alu_b_q, alu_b_d;
   logic               alu_neg_q, alu_neg_d;
   logic [WIDTH-1:0]   shifted;

   // Next-state, datapath and registered ALU drive; ALU operands are
   // precomputed from the next R/Q so they are valid throughout each ITER cycle.
   always_comb begin
      state_d   = state_q;
      r_d       = r_q;
      q_d       = q_q;
      d_d       = d_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dbz_d     = dbz_q;
      shifted   = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               d_d   = Divisor;
               q_d   = Dividend;
               r_d   = '0;
               cnt_d = '0;
               if (Divisor == '0) begin
                  state_d = S_DONE;
                  quo_d   = '1;
                  rem_d   = Dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = S_ITER;
                  dbz_d   = 1'b0;
               end
            end
         end
         S_ITER: begin
            if (AluCarryOut) begin
               r_d = AluResult;
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               r_d = shifted;
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_DONE;
               quo_d   = q_d;
               rem_d   = r_d;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d    = (state_d == S_ITER);
      done_d    = (state_d == S_DONE);
      alu_neg_d = (state_d == S_ITER);
      alu_a_d   = (state_d == S_ITER) ? {r_d[WIDTH-2:0], q_d[WIDTH-1]} : '0;
      alu_b_d   = (state_d == S_ITER) ? d_d : '0;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         r_q       <= '0;
         q_q       <= '0;
         d_q       <= '0;
         cnt_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dbz_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_neg_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         r_q       <= r_d;
         q_q       <= q_d;
         d_q       <= d_d;
         cnt_q     <= cnt_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dbz_q     <= dbz_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_neg_q <= alu_neg_d;
      end
   end

   assign Busy       = busy_q;
   assign Done       = done_q;
   assign Quotient   = quo_q;
   assign Remainder  = rem_q;
   assign DivByZero  = dbz_q;
   assign AluA       = alu_a_q;
   assign AluB       = alu_b_q;
   assign AluBNegate = alu_neg_q;
   assign AluAInvert = 1'b0;
   assign AluOp      = OP_ADD;

endmodule
